// File: rtl/xbar_select_ctrl_if.sv
// Crossbar select controller bus: allocator grants and flit status in,
// per-output mux selects, busy flags and sticky error flags out.
interface xbar_select_ctrl_if #(
    parameter int N_PORTS = 5,
    parameter int SEL_W   = 3
);

    logic [N_PORTS-1:0]       grant;
    logic [N_PORTS*SEL_W-1:0] req_dir;
    logic [N_PORTS-1:0]       flit_vld;
    logic [N_PORTS-1:0]       flit_tail;
    logic [N_PORTS*SEL_W-1:0] sel;
    logic [N_PORTS-1:0]       out_busy;
    logic                     err_conflict;
    logic                     err_timeout;

    // Allocator / traffic side
    modport master (
        output grant, req_dir, flit_vld, flit_tail,
        input  sel, out_busy, err_conflict, err_timeout
    );

    // Select controller side
    modport slave (
        input  grant, req_dir, flit_vld, flit_tail,
        output sel, out_busy, err_conflict, err_timeout
    );

endinterface

// File: rtl/xbar_select_ctrl.sv
// Crossbar output select controller: one lock FSM per output turns allocator
// grants into mux selects and releases the output on the owner's tail flit
// or when the lock has been held too long.
module xbar_select_ctrl #(
    parameter int N_PORTS = 5,
    parameter int SEL_W   = 3,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               reset,
    xbar_select_ctrl_if.slave bus
);

    // A zero timeout still needs a legal one-bit counter; it simply never moves.
    localparam int               AGE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W-1:0] IDLE_SEL = '1;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } out_state_e;

    out_state_e               state_q  [N_PORTS];
    out_state_e               state_d  [N_PORTS];
    logic [SEL_W-1:0]         owner_q  [N_PORTS];
    logic [SEL_W-1:0]         owner_d  [N_PORTS];
    logic [AGE_W-1:0]         age_q    [N_PORTS];
    logic [AGE_W-1:0]         age_d    [N_PORTS];
    logic [N_PORTS-1:0]       hit      [N_PORTS];
    logic [N_PORTS-1:0]       owner_oh [N_PORTS];
    logic [N_PORTS-1:0]       released;
    logic [N_PORTS-1:0]       timed_out;
    logic                     conflict_ev;
    logic                     timeout_ev;
    logic                     err_conflict_q;
    logic                     err_timeout_q;
    logic [N_PORTS*SEL_W-1:0] sel_vec;
    logic [N_PORTS-1:0]       busy_vec;

    // Lowest set bit wins when several inputs ask for the same free output.
    function automatic logic [SEL_W-1:0] lowest_index(input logic [N_PORTS-1:0] v);
        lowest_index = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_index = SEL_W'(i);
            end
        end
    endfunction

    // Which granted inputs target each output; directions >= N_PORTS match nothing.
    always_comb begin
        for (int o = 0; o < N_PORTS; o++) begin
            hit[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                hit[o][i] = bus.grant[i] && (bus.req_dir[i*SEL_W +: SEL_W] == SEL_W'(o));
            end
        end
    end

    // Release events per output: owner's tail flit, or the age limit being hit.
    always_comb begin
        released  = '0;
        timed_out = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            owner_oh[o] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                owner_oh[o][i] = (owner_q[o] == SEL_W'(i));
            end
            timed_out[o] = (TIMEOUT > 0) && (state_q[o] == ST_LOCKED) && (age_q[o] == AGE_MAX);
            released[o]  = (state_q[o] == ST_LOCKED) &&
                           ((owner_oh[o] & bus.flit_vld & bus.flit_tail) != '0);
        end
    end

    // Next-state logic: timeout beats tail, and a tail frees the output before new grants are considered.
    always_comb begin
        conflict_ev = 1'b0;
        timeout_ev  = 1'b0;
        for (int o = 0; o < N_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            age_d[o]   = age_q[o];
            if (timed_out[o]) begin
                state_d[o] = ST_IDLE;
                age_d[o]   = '0;
                timeout_ev = 1'b1;
                if ((hit[o] & ~owner_oh[o]) != '0) begin
                    conflict_ev = 1'b1;
                end
            end else if ((state_q[o] == ST_IDLE) || released[o]) begin
                if (hit[o] != '0) begin
                    state_d[o] = ST_LOCKED;
                    owner_d[o] = lowest_index(hit[o]);
                    age_d[o]   = '0;
                    if ((hit[o] & (hit[o] - N_PORTS'(1))) != '0) begin
                        conflict_ev = 1'b1;
                    end
                end else begin
                    state_d[o] = ST_IDLE;
                    age_d[o]   = '0;
                end
            end else begin
                if (age_q[o] < AGE_MAX) begin
                    age_d[o] = age_q[o] + AGE_W'(1);
                end
                if ((hit[o] & ~owner_oh[o]) != '0) begin
                    conflict_ev = 1'b1;
                end
            end
        end
    end

    // Per-output state, owner and age registers plus the sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                age_q[o]   <= '0;
            end
            err_conflict_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            for (int o = 0; o < N_PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                age_q[o]   <= age_d[o];
            end
            err_conflict_q <= err_conflict_q | conflict_ev;
            err_timeout_q  <= err_timeout_q | timeout_ev;
        end
    end

    // Output decode: a locked output selects its owner, an idle one selects nothing.
    always_comb begin
        sel_vec  = '1;
        busy_vec = '0;
        for (int o = 0; o < N_PORTS; o++) begin
            if (state_q[o] == ST_LOCKED) begin
                sel_vec[o*SEL_W +: SEL_W] = owner_q[o];
                busy_vec[o]               = 1'b1;
            end else begin
                sel_vec[o*SEL_W +: SEL_W] = IDLE_SEL;
                busy_vec[o]               = 1'b0;
            end
        end
    end

    assign bus.sel          = sel_vec;
    assign bus.out_busy     = busy_vec;
    assign bus.err_conflict = err_conflict_q;
    assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_xbar_select_ctrl.sv
// Bench for xbar_select_ctrl: three configurations (5/3/timeout 4, 2/2/no
// timeout, 7/3/timeout 6) checked every cycle against a packet-level model,
// plus directed scenarios on the 5-port instance with literal expectations.
module tb_xbar_select_ctrl;

    localparam int NC = 3;

    logic clk;
    logic reset;

    logic [6:0] st_g   [NC];
    logic [6:0] st_v   [NC];
    logic [6:0] st_t   [NC];
    logic [2:0] st_dir [NC][7];

    logic [31:0] act_sel  [NC];
    logic [31:0] act_busy [NC];
    logic [31:0] act_ec   [NC];
    logic [31:0] act_et   [NC];

    int m_lock  [NC][7];
    int m_owner [NC][7];
    int m_age   [NC][7];
    int m_errc  [NC];
    int m_errt  [NC];

    int checks;
    int passes;
    bit check_en;

    xbar_select_ctrl_if #(.N_PORTS(5), .SEL_W(3)) bus_a ();
    xbar_select_ctrl_if #(.N_PORTS(2), .SEL_W(2)) bus_b ();
    xbar_select_ctrl_if #(.N_PORTS(7), .SEL_W(3)) bus_c ();

    xbar_select_ctrl #(.N_PORTS(5), .SEL_W(3), .TIMEOUT(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    xbar_select_ctrl #(.N_PORTS(2), .SEL_W(2), .TIMEOUT(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    xbar_select_ctrl #(.N_PORTS(7), .SEL_W(3), .TIMEOUT(6)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    function automatic int np(int c);
        return (c == 0) ? 5 : (c == 1) ? 2 : 7;
    endfunction

    function automatic int sw(int c);
        return (c == 1) ? 2 : 3;
    endfunction

    function automatic int tmo(int c);
        return (c == 0) ? 4 : (c == 1) ? 0 : 6;
    endfunction

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the three interfaces from the stimulus arrays
    always_comb begin
        bus_a.grant     = st_g[0][4:0];
        bus_a.flit_vld  = st_v[0][4:0];
        bus_a.flit_tail = st_t[0][4:0];
        bus_a.req_dir   = '0;
        for (int i = 0; i < 5; i++) bus_a.req_dir[i*3 +: 3] = st_dir[0][i];
        bus_b.grant     = st_g[1][1:0];
        bus_b.flit_vld  = st_v[1][1:0];
        bus_b.flit_tail = st_t[1][1:0];
        bus_b.req_dir   = '0;
        for (int i = 0; i < 2; i++) bus_b.req_dir[i*2 +: 2] = st_dir[1][i][1:0];
        bus_c.grant     = st_g[2];
        bus_c.flit_vld  = st_v[2];
        bus_c.flit_tail = st_t[2];
        bus_c.req_dir   = '0;
        for (int i = 0; i < 7; i++) bus_c.req_dir[i*3 +: 3] = st_dir[2][i];
    end

    assign act_sel[0]  = 32'(bus_a.sel);
    assign act_sel[1]  = 32'(bus_b.sel);
    assign act_sel[2]  = 32'(bus_c.sel);
    assign act_busy[0] = 32'(bus_a.out_busy);
    assign act_busy[1] = 32'(bus_b.out_busy);
    assign act_busy[2] = 32'(bus_c.out_busy);
    assign act_ec[0]   = 32'(bus_a.err_conflict);
    assign act_ec[1]   = 32'(bus_b.err_conflict);
    assign act_ec[2]   = 32'(bus_c.err_conflict);
    assign act_et[0]   = 32'(bus_a.err_timeout);
    assign act_et[1]   = 32'(bus_b.err_timeout);
    assign act_et[2]   = 32'(bus_c.err_timeout);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Packet-level model: evaluated once per rising edge on the inputs held that cycle
    task automatic modelUpdate();
        int want[$];
        int d;
        for (int c = 0; c < NC; c++) begin
            if (!reset) begin
                for (int o = 0; o < 7; o++) begin
                    m_lock[c][o]  = 0;
                    m_owner[c][o] = 0;
                    m_age[c][o]   = 0;
                end
                m_errc[c] = 0;
                m_errt[c] = 0;
            end else begin
                for (int o = 0; o < np(c); o++) begin
                    want.delete();
                    for (int i = 0; i < np(c); i++) begin
                        d = int'(st_dir[c][i]) % (1 << sw(c));
                        if (st_g[c][i] && d == o) want.push_back(i);
                    end
                    if (m_lock[c][o] != 0 && tmo(c) > 0 && m_age[c][o] == tmo(c)) begin
                        m_lock[c][o] = 0;
                        m_errt[c]    = 1;
                        foreach (want[k]) if (want[k] != m_owner[c][o]) m_errc[c] = 1;
                    end else begin
                        if (m_lock[c][o] != 0 && st_v[c][m_owner[c][o]] && st_t[c][m_owner[c][o]])
                            m_lock[c][o] = 0;
                        if (m_lock[c][o] == 0) begin
                            if (want.size() > 0) begin
                                m_lock[c][o]  = 1;
                                m_owner[c][o] = want[0];
                                m_age[c][o]   = 0;
                            end
                            if (want.size() > 1) m_errc[c] = 1;
                        end else begin
                            foreach (want[k]) if (want[k] != m_owner[c][o]) m_errc[c] = 1;
                            if (m_age[c][o] < tmo(c)) m_age[c][o]++;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [31:0] expSel(int c);
        logic [31:0] v;
        int s;
        v = '0;
        for (int o = 0; o < np(c); o++) begin
            s = (m_lock[c][o] != 0) ? m_owner[c][o] : (1 << sw(c)) - 1;
            v = v | (32'(s) << (o * sw(c)));
        end
        return v;
    endfunction

    function automatic logic [31:0] expBusy(int c);
        logic [31:0] v;
        v = '0;
        for (int o = 0; o < np(c); o++) if (m_lock[c][o] != 0) v[o] = 1'b1;
        return v;
    endfunction

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        int bad;
        int s;
        if (check_en) begin
            for (int c = 0; c < NC; c++) begin
                checkOutput($sformatf("model_sel[%0d]", c), act_sel[c], expSel(c));
                checkOutput($sformatf("model_busy[%0d]", c), act_busy[c], expBusy(c));
                checkOutput($sformatf("model_err_conflict[%0d]", c), act_ec[c], 32'(m_errc[c]));
                checkOutput($sformatf("model_err_timeout[%0d]", c), act_et[c], 32'(m_errt[c]));
                bad = 0;
                for (int o = 0; o < np(c); o++) begin
                    s = int'((act_sel[c] >> (o * sw(c))) & 32'((1 << sw(c)) - 1));
                    if (s != (1 << sw(c)) - 1 && s >= np(c)) bad++;
                end
                checkOutput($sformatf("sel_legal[%0d]", c), 32'(bad), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    // Drive one cycle of traffic on the 5-port instance and let one edge pass
    task automatic applyStimulus(input logic [6:0] g, input logic [20:0] dirs,
                                 input logic [6:0] v, input logic [6:0] t);
        st_g[0] = g;
        st_v[0] = v;
        st_t[0] = t;
        for (int i = 0; i < 7; i++) st_dir[0][i] = dirs[i*3 +: 3];
        step();
    endtask

    function automatic logic [20:0] dirOf(int i, int o);
        return 21'(o) << (3 * i);
    endfunction

    function automatic logic [31:0] sel0(int o);
        return (act_sel[0] >> (o * 3)) & 32'd7;
    endfunction

    initial begin
        checks   = 0;
        passes   = 0;
        check_en = 1'b0;
        reset    = 1'b0;
        for (int c = 0; c < NC; c++) begin
            st_g[c] = '0;
            st_v[c] = '0;
            st_t[c] = '0;
            for (int i = 0; i < 7; i++) st_dir[c][i] = '0;
        end
        step();
        check_en = 1'b1;
        step();
        reset = 1'b1;
        $display("[TB] reset state");
        checkOutput("reset_sel", act_sel[0], 32'h7FFF);
        checkOutput("reset_busy", act_busy[0], 32'h0);
        checkOutput("reset_err_conflict", act_ec[0], 32'h0);
        checkOutput("reset_err_timeout", act_et[0], 32'h0);

        $display("[TB] basic lock and tail release");
        applyStimulus(7'b0000010, dirOf(1, 3), 7'b0, 7'b0);
        checkOutput("lock_sel3", sel0(3), 32'd1);
        checkOutput("lock_busy", act_busy[0], 32'h08);
        applyStimulus(7'b0, 21'b0, 7'b0000100, 7'b0000100);
        checkOutput("nonowner_tail_sel3", sel0(3), 32'd1);
        applyStimulus(7'b0, 21'b0, 7'b0, 7'b0);
        applyStimulus(7'b0, 21'b0, 7'b0000010, 7'b0000010);
        checkOutput("tail_sel3", sel0(3), 32'd7);
        checkOutput("tail_busy", act_busy[0], 32'h0);
        applyStimulus(7'b0, 21'b0, 7'b0000010, 7'b0000010);
        checkOutput("idle_tail_busy", act_busy[0], 32'h0);

        $display("[TB] out-of-range directions");
        applyStimulus(7'b0001001, dirOf(3, 5) | dirOf(0, 7), 7'b0, 7'b0);
        checkOutput("bad_dir_busy", act_busy[0], 32'h0);
        checkOutput("bad_dir_err", act_ec[0], 32'h0);

        $display("[TB] conflicts");
        applyStimulus(7'b0000101, dirOf(0, 4) | dirOf(2, 4), 7'b0, 7'b0);
        checkOutput("conflict_sel4", sel0(4), 32'd0);
        checkOutput("conflict_err", act_ec[0], 32'h1);
        applyStimulus(7'b0000100, dirOf(2, 4), 7'b0, 7'b0);
        checkOutput("locked_other_sel4", sel0(4), 32'd0);
        applyStimulus(7'b0000001, dirOf(0, 4), 7'b0, 7'b0);
        checkOutput("locked_owner_sel4", sel0(4), 32'd0);
        applyStimulus(7'b0, 21'b0, 7'b0000001, 7'b0000001);
        checkOutput("conflict_release_sel4", sel0(4), 32'd7);
        checkOutput("conflict_sticky", act_ec[0], 32'h1);

        $display("[TB] back-to-back handover");
        applyStimulus(7'b0000001, dirOf(0, 1), 7'b0, 7'b0);
        checkOutput("b2b_first_sel1", sel0(1), 32'd0);
        applyStimulus(7'b0010000, dirOf(4, 1), 7'b0000001, 7'b0000001);
        checkOutput("b2b_second_sel1", sel0(1), 32'd4);
        checkOutput("b2b_busy", act_busy[0], 32'h02);
        applyStimulus(7'b0, 21'b0, 7'b0010000, 7'b0010000);
        checkOutput("b2b_release_sel1", sel0(1), 32'd7);

        $display("[TB] one input owning two outputs");
        applyStimulus(7'b0000100, dirOf(2, 0), 7'b0, 7'b0);
        applyStimulus(7'b0000100, dirOf(2, 3), 7'b0, 7'b0);
        checkOutput("multi_sel0", sel0(0), 32'd2);
        checkOutput("multi_sel3", sel0(3), 32'd2);
        checkOutput("multi_busy", act_busy[0], 32'h09);
        applyStimulus(7'b0, 21'b0, 7'b0000100, 7'b0000100);
        checkOutput("multi_release_busy", act_busy[0], 32'h0);
        checkOutput("pre_timeout_err", act_et[0], 32'h0);

        $display("[TB] timeout");
        applyStimulus(7'b0001000, dirOf(3, 2), 7'b0, 7'b0);
        checkOutput("timeout_hold_0", sel0(2), 32'd3);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(7'b0, 21'b0, 7'b0, 7'b0);
            checkOutput($sformatf("timeout_hold_%0d", k), sel0(2), 32'd3);
            checkOutput($sformatf("timeout_flag_low_%0d", k), act_et[0], 32'h0);
        end
        applyStimulus(7'b0, 21'b0, 7'b0, 7'b0);
        checkOutput("timeout_sel2", sel0(2), 32'd7);
        checkOutput("timeout_err", act_et[0], 32'h1);

        $display("[TB] reset mid-packet");
        applyStimulus(7'b0010011, dirOf(0, 0) | dirOf(1, 1) | dirOf(4, 2), 7'b0, 7'b0);
        checkOutput("three_locked_busy", act_busy[0], 32'h07);
        checkOutput("three_locked_sel", act_sel[0], 32'h7F08);
        reset = 1'b0;
        applyStimulus(7'b0001000, dirOf(3, 3), 7'b0000001, 7'b0000001);
        reset = 1'b1;
        checkOutput("midreset_sel", act_sel[0], 32'h7FFF);
        checkOutput("midreset_busy", act_busy[0], 32'h0);
        checkOutput("midreset_err_conflict", act_ec[0], 32'h0);
        checkOutput("midreset_err_timeout", act_et[0], 32'h0);
        applyStimulus(7'b0, 21'b0, 7'b0000010, 7'b0000010);
        checkOutput("post_reset_tail_busy", act_busy[0], 32'h0);
        checkOutput("post_reset_tail_sel", act_sel[0], 32'h7FFF);

        $display("[TB] random traffic on all configurations");
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NC; c++) begin
                st_g[c] = 7'($urandom) & 7'($urandom);
                st_v[c] = 7'($urandom);
                st_t[c] = 7'($urandom) & 7'($urandom);
                for (int i = 0; i < 7; i++) st_dir[c][i] = 3'($urandom_range(0, 7));
            end
            reset = (n == 200) ? 1'b0 : 1'b1;
            step();
        end
        reset = 1'b1;
        for (int c = 0; c < NC; c++) begin
            st_g[c] = '0;
            st_v[c] = '0;
            st_t[c] = '0;
        end
        step();

        check_en = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
